// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// NREQ writeback sources. The accepted write is registered and presented to
// the register file one cycle after the handshake. Per-read-port hazard flags
// tell decode that a matching write is still waiting for its grant.
module rf_wb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 4,
    parameter int unsigned DW   = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_vld_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0]   req_rdy_o,
    output logic              we_o,
    output logic [AW-1:0]     dst_addr_o,
    output logic [DW-1:0]     dst_o,
    input  logic [AW-1:0]     p0_addr_i,
    input  logic [AW-1:0]     p1_addr_i,
    output logic              p0_haz_o,
    output logic              p1_haz_o,
    output logic [7:0]        busy_cnt_o
);

    // Pointer needs at least one bit even when NREQ==1 (it then stays 0).
    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
    logic            we_q, we_d;
    logic [AW-1:0]   dst_addr_q, dst_addr_d;
    logic [DW-1:0]   dst_q, dst_d;
    logic [7:0]      busy_cnt_q, busy_cnt_d;

    logic            grant_vld;
    logic [AW-1:0]   grant_addr;
    logic [DW-1:0]   grant_data;
    logic            stall;

    // Round-robin pick: first scan indices >= rr_ptr, then wrap to the low
    // indices; any valid index >= rr_ptr is taken in the first pass.
    always_comb begin
        int unsigned ptr;
        req_rdy_o  = '0;
        grant_vld  = 1'b0;
        grant_addr = '0;
        grant_data = '0;
        rr_ptr_d   = rr_ptr_q;
        ptr        = 32'(rr_ptr_q);
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!grant_vld && req_vld_i[i] && (i >= ptr)) begin
                grant_vld    = 1'b1;
                req_rdy_o[i] = 1'b1;
                grant_addr   = req_addr_i[i*AW +: AW];
                grant_data   = req_data_i[i*DW +: DW];
                rr_ptr_d     = (i == NREQ - 1) ? '0 : PtrW'(i + 1);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!grant_vld && req_vld_i[i]) begin
                grant_vld    = 1'b1;
                req_rdy_o[i] = 1'b1;
                grant_addr   = req_addr_i[i*AW +: AW];
                grant_data   = req_data_i[i*DW +: DW];
                rr_ptr_d     = (i == NREQ - 1) ? '0 : PtrW'(i + 1);
            end
        end
    end

    // Hazards come only from pending, un-granted writes; r0 never hazards
    // and the granted write is bypassed by the register file.
    always_comb begin
        p0_haz_o = 1'b0;
        p1_haz_o = 1'b0;
        stall    = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_vld_i[i] && !req_rdy_o[i]) begin
                stall = 1'b1;
                if ((req_addr_i[i*AW +: AW] == p0_addr_i) && (p0_addr_i != '0)) begin
                    p0_haz_o = 1'b1;
                end
                if ((req_addr_i[i*AW +: AW] == p1_addr_i) && (p1_addr_i != '0)) begin
                    p1_haz_o = 1'b1;
                end
            end
        end
    end

    // Next-state for the write port and the stall counter; r0 writes consume
    // the grant but never raise we.
    always_comb begin
        we_d       = grant_vld && (grant_addr != '0);
        dst_addr_d = grant_vld ? grant_addr : dst_addr_q;
        dst_d      = grant_vld ? grant_data : dst_q;
        busy_cnt_d = busy_cnt_q;
        if (stall && (busy_cnt_q != 8'hFF)) begin
            busy_cnt_d = busy_cnt_q + 8'd1;
        end
    end

    // State registers; reset drops any registered write immediately.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            we_q       <= 1'b0;
            dst_addr_q <= '0;
            dst_q      <= '0;
            busy_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            we_q       <= we_d;
            dst_addr_q <= dst_addr_d;
            dst_q      <= dst_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign we_o       = we_q;
    assign dst_addr_o = dst_addr_q;
    assign dst_o      = dst_q;
    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (NREQ=3, AW=4, DW=16).
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_vld;
    logic [11:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  req_rdy;
    logic        we;
    logic [3:0]  dst_addr;
    logic [15:0] dst;
    logic [3:0]  p0_addr, p1_addr;
    logic        p0_haz, p1_haz;
    logic [7:0]  busy_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.NREQ(3), .AW(4), .DW(16)) dut (
        .clk_i      (clk),
        .rst_n      (rst_n),
        .req_vld_i  (req_vld),
        .req_addr_i (req_addr),
        .req_data_i (req_data),
        .req_rdy_o  (req_rdy),
        .we_o       (we),
        .dst_addr_o (dst_addr),
        .dst_o      (dst),
        .p0_addr_i  (p0_addr),
        .p1_addr_i  (p1_addr),
        .p0_haz_o   (p0_haz),
        .p1_haz_o   (p1_haz),
        .busy_cnt_o (busy_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b1;
        req_vld  = '0;
        req_addr = '0;
        req_data = '0;
        p0_addr  = '0;
        p1_addr  = '0;

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        chk("rst_we", 32'(we), 0);
        chk("rst_dst_addr", 32'(dst_addr), 0);
        chk("rst_dst", 32'(dst), 0);
        chk("rst_busy", 32'(busy_cnt), 0);
        chk("rst_rdy", 32'(req_rdy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single request from requester 1
        req_vld  = 3'b010;
        req_addr = {4'd0, 4'd5, 4'd0};
        req_data = {16'h0000, 16'hBEEF, 16'h0000};
        #1 chk("single_rdy", 32'(req_rdy), 32'b010);
        tick();
        req_vld = '0;
        #1;
        chk("single_we", 32'(we), 1);
        chk("single_addr", 32'(dst_addr), 5);
        chk("single_dst", 32'(dst), 32'hBEEF);
        chk("single_rdy_off", 32'(req_rdy), 0);
        chk("single_busy", 32'(busy_cnt), 0);

        // All valid: pointer is 2, so grants run 2,0,1,2,0
        req_addr = {4'd3, 4'd2, 4'd1};
        req_data = {16'h00A2, 16'h00A1, 16'h00A0};
        req_vld  = 3'b111;
        #1 chk("rr_first", 32'(req_rdy), 32'b100);
        tick();
        chk("rr_first_we", 32'(we), 1);
        chk("rr_first_addr", 32'(dst_addr), 3);
        chk("rr_first_busy", 32'(busy_cnt), 1);
        for (int k = 0; k < 4; k++) begin
            chk("rr_rdy", 32'(req_rdy), 32'(1) << (k % 3));
            tick();
            chk("rr_addr", 32'(dst_addr), 32'((k % 3) + 1));
            chk("rr_dst", 32'(dst), 32'(16'hA0 + (k % 3)));
            chk("rr_busy", 32'(busy_cnt), 32'(2 + k));
        end
        req_vld = '0;
        #1 chk("idle_rdy", 32'(req_rdy), 0);
        tick();
        chk("idle_we", 32'(we), 0);
        chk("idle_addr_hold", 32'(dst_addr), 1);
        chk("idle_busy_hold", 32'(busy_cnt), 5);

        // r0 write: pointer is 1, requester 0 still wins after wrap
        req_addr = {4'd3, 4'd2, 4'd0};
        req_vld  = 3'b001;
        #1 chk("r0_rdy", 32'(req_rdy), 32'b001);
        tick();
        req_vld = '0;
        #1;
        chk("r0_we", 32'(we), 0);
        chk("r0_busy", 32'(busy_cnt), 5);

        // Move pointer to 0 via requester 2
        req_addr = {4'd9, 4'd2, 4'd0};
        req_vld  = 3'b100;
        #1 chk("p2_rdy", 32'(req_rdy), 32'b100);
        tick();
        req_vld = '0;
        #1;
        chk("p2_we", 32'(we), 1);
        chk("p2_addr", 32'(dst_addr), 9);

        // Hazard: two writes to r7, requester 1 waits
        req_addr = {4'd9, 4'd7, 4'd7};
        req_data = {16'h0000, 16'h00B1, 16'h00B0};
        p0_addr  = 4'd7;
        p1_addr  = 4'd7;
        req_vld  = 3'b011;
        #1;
        chk("haz_rdy", 32'(req_rdy), 32'b001);
        chk("haz_p0", 32'(p0_haz), 1);
        chk("haz_p1", 32'(p1_haz), 1);
        tick();
        chk("haz_dst0", 32'(dst), 32'hB0);
        chk("haz_busy", 32'(busy_cnt), 6);
        req_vld = 3'b010;
        #1;
        chk("haz2_rdy", 32'(req_rdy), 32'b010);
        chk("haz2_p0", 32'(p0_haz), 0);
        chk("haz2_p1", 32'(p1_haz), 0);
        tick();
        req_vld = '0;
        #1;
        chk("haz2_we", 32'(we), 1);
        chk("haz2_addr", 32'(dst_addr), 7);
        chk("haz2_dst", 32'(dst), 32'hB1);
        chk("haz2_busy", 32'(busy_cnt), 6);

        // Asynchronous reset mid-cycle while we=1
        #1 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(we), 0);
        chk("arst_addr", 32'(dst_addr), 0);
        chk("arst_dst", 32'(dst), 0);
        chk("arst_busy", 32'(busy_cnt), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        p0_addr = '0;
        p1_addr = '0;
        req_vld = 3'b011;
        #1 chk("arst_ptr", 32'(req_rdy), 32'b001);

        // Saturation: two requesters held for 300 cycles
        for (int i = 0; i < 300; i++) begin
            chk("sat_rdy", 32'(req_rdy), (i % 2 == 0) ? 32'b001 : 32'b010);
            tick();
            if (i == 199) chk("sat_busy_200", 32'(busy_cnt), 200);
        end
        chk("sat_busy_ff", 32'(busy_cnt), 32'hFF);
        chk("sat_we", 32'(we), 1);
        req_vld = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
